// File: rtl/dut_nbit_addsub_if.sv
// Operand/result stream and register-port bundle for dut_nbit_addsub.
interface dut_nbit_addsub_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] Value_a;
  logic [WIDTH-1:0] Value_b;
  logic             Data_val;
  logic [WIDTH-1:0] Sum_result;
  logic             Sum_carry;
  logic             Data_ready;
  logic [2:0]       Des_address;
  logic [7:0]       Des_value;
  logic             Des_req_valid;
  logic             Des_wr_rd;
  logic [7:0]       Des_rd_value;

  modport master (
    output Value_a,
    output Value_b,
    output Data_val,
    input  Sum_result,
    input  Sum_carry,
    input  Data_ready,
    output Des_address,
    output Des_value,
    output Des_req_valid,
    output Des_wr_rd,
    input  Des_rd_value
  );

  modport slave (
    input  Value_a,
    input  Value_b,
    input  Data_val,
    output Sum_result,
    output Sum_carry,
    output Data_ready,
    input  Des_address,
    input  Des_value,
    input  Des_req_valid,
    input  Des_wr_rd,
    output Des_rd_value
  );
endinterface

// File: rtl/dut_nbit_addsub.sv
// Segmented pipelined add/sub with saturate mode, sticky overflow and
// op/overflow counters behind an 8-bit register port.
module dut_nbit_addsub #(
  parameter int         WIDTH   = 16,
  parameter int         SEG_W   = 8,
  parameter logic [7:0] VERSION = 8'h02
) (
  input logic              clk,
  input logic              reset_n,
  dut_nbit_addsub_if.slave bus
);
  localparam int NSEG = WIDTH / SEG_W;

  typedef struct packed {
    logic             v;
    logic             sub;
    logic             sat;
    logic             cy;
    logic [WIDTH-1:0] r;
  } stg_t;

  logic             ctrl_en;
  logic             ctrl_sub;
  logic             ctrl_sat;
  stg_t             in_s;
  logic [WIDTH-1:0] in_b;

  // Subtract is A + ~B + 1: the +1 enters as carry-in of segment 0.
  always_comb begin
    in_s.v   = bus.Data_val & ctrl_en;
    in_s.sub = ctrl_sub;
    in_s.sat = ctrl_sat;
    in_s.cy  = ctrl_sub;
    in_s.r   = bus.Value_a;
    in_b     = ctrl_sub ? ~bus.Value_b : bus.Value_b;
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int BW = WIDTH - k * SEG_W;

    stg_t           src;
    stg_t           nxt;
    stg_t           q;
    logic [BW-1:0]  b_src;
    logic [SEG_W:0] sum;

    if (k == 0) begin : g_in
      assign src   = in_s;
      assign b_src = in_b;
    end else begin : g_mid
      assign src   = g_seg[k-1].q;
      assign b_src = g_seg[k-1].g_b.b_q;
    end

    // r carries finished low segments and untouched high A segments.
    always_comb begin
      sum = {1'b0, src.r[k*SEG_W +: SEG_W]}
          + {1'b0, b_src[SEG_W-1:0]}
          + {{SEG_W{1'b0}}, src.cy};
      nxt = src;
      nxt.r[k*SEG_W +: SEG_W] = sum[SEG_W-1:0];
      nxt.cy = sum[SEG_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q <= '0;
      end else begin
        q.v <= src.v;
        if (src.v) q <= nxt;
      end
    end

    // Only the not-yet-consumed B segments travel on.
    if (k < NSEG - 1) begin : g_b
      logic [BW-SEG_W-1:0] b_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          b_q <= '0;
        end else if (src.v) begin
          b_q <= b_src[BW-1:SEG_W];
        end
      end
    end
  end

  stg_t             last;
  logic             ovf;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ready_q;
  logic             ovf_q;

  assign last = g_seg[NSEG-1].q;
  assign ovf  = last.sub ? ~last.cy : last.cy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ready_q <= last.v;
      ovf_q   <= last.v & ovf;
      if (last.v) begin
        carry_q <= last.cy;
        sum_q   <= (last.sat && ovf) ? {WIDTH{~last.sub}}
                                     : last.r;
      end
    end
  end

  assign bus.Sum_result = sum_q;
  assign bus.Sum_carry  = carry_q;
  assign bus.Data_ready = ready_q;

  logic        wr_en;
  logic        rd_en;
  logic        clr;
  logic        ovf_evt;
  logic        sticky;
  logic [15:0] opcnt;
  logic [7:0]  ovfcnt;
  logic [7:0]  shadow;
  logic [7:0]  rd_mux;
  logic [7:0]  rd_q;

  assign wr_en   = bus.Des_req_valid & bus.Des_wr_rd;
  assign rd_en   = bus.Des_req_valid & ~bus.Des_wr_rd;
  assign clr     = wr_en && (bus.Des_address == 3'd0)
                && bus.Des_value[3];
  assign ovf_evt = ready_q & ovf_q;

  // A new overflow beats W1C; clr beats any same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en  <= 1'b1;
      ctrl_sub <= 1'b0;
      ctrl_sat <= 1'b0;
      sticky   <= 1'b0;
      opcnt    <= '0;
      ovfcnt   <= '0;
      shadow   <= '0;
    end else begin
      if (wr_en && bus.Des_address == 3'd0) begin
        ctrl_en  <= bus.Des_value[0];
        ctrl_sub <= bus.Des_value[1];
        ctrl_sat <= bus.Des_value[2];
      end
      if (ovf_evt) begin
        sticky <= 1'b1;
      end else if (wr_en && bus.Des_address == 3'd1
                   && bus.Des_value[0]) begin
        sticky <= 1'b0;
      end
      if (clr) begin
        opcnt  <= '0;
        ovfcnt <= '0;
        shadow <= '0;
      end else begin
        if (ready_q && opcnt != 16'hFFFF) begin
          opcnt <= opcnt + 16'd1;
        end
        if (ovf_evt && ovfcnt != 8'hFF) begin
          ovfcnt <= ovfcnt + 8'd1;
        end
        if (rd_en && bus.Des_address == 3'd2) begin
          shadow <= opcnt[15:8];
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.Des_address)
      3'd0:    rd_mux = {5'b0, ctrl_sat, ctrl_sub, ctrl_en};
      3'd1:    rd_mux = {7'b0, sticky};
      3'd2:    rd_mux = opcnt[7:0];
      3'd3:    rd_mux = shadow;
      3'd4:    rd_mux = ovfcnt;
      3'd5:    rd_mux = VERSION;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= rd_mux;
    end
  end

  assign bus.Des_rd_value = rd_q;
endmodule

// File: tb/tb_dut_nbit_addsub.sv
// Randomized bench for dut_nbit_addsub against an arithmetic
// reference model with a due-cycle scoreboard and register model.
module tb_dut_nbit_addsub;
  localparam int WIDTH = 16;
  localparam int SEG_W = 8;
  localparam int NSEG  = WIDTH / SEG_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dut_nbit_addsub_if #(.WIDTH(WIDTH)) bus ();

  dut_nbit_addsub #(
    .WIDTH(WIDTH),
    .SEG_W(SEG_W),
    .VERSION(8'h02)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int               due;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  logic        m_en, m_sub, m_sat, m_sticky, m_clr_now;
  logic [15:0] m_opcnt;
  logic [7:0]  m_ovfcnt, m_shadow;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b1;
    m_sub = 1'b0;
    m_sat = 1'b0;
    m_sticky = 1'b0;
    m_clr_now = 1'b0;
    m_opcnt = '0;
    m_ovfcnt = '0;
    m_shadow = '0;
    exp_q.delete();
  endtask

  function automatic exp_t predict(logic [WIDTH-1:0] a,
      logic [WIDTH-1:0] b, logic sub, logic sat, int due);
    exp_t e;
    longint s;
    e.due = due;
    if (!sub) begin
      s = longint'(a) + longint'(b);
      e.carry = s[WIDTH];
      e.sum = WIDTH'(s);
      e.ovf = e.carry;
      if (sat && e.ovf) e.sum = '1;
    end else begin
      e.carry = (a >= b);
      e.sum = a - b;
      e.ovf = !e.carry;
      if (sat && e.ovf) e.sum = '0;
    end
    return e;
  endfunction

  function automatic logic [7:0] m_read(logic [2:0] addr);
    case (addr)
      3'd0: return {5'b0, m_sat, m_sub, m_en};
      3'd1: return {7'b0, m_sticky};
      3'd2: return m_opcnt[7:0];
      3'd3: return m_shadow;
      3'd4: return m_ovfcnt;
      3'd5: return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (bus.Data_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("due_cycle", cyc, e.due);
        check("sum", bus.Sum_result, e.sum);
        check("carry", bus.Sum_carry, e.carry);
        if (!m_clr_now) begin
          if (m_opcnt != 16'hFFFF) m_opcnt++;
          if (e.ovf && m_ovfcnt != 8'hFF) m_ovfcnt++;
        end
        if (e.ovf) m_sticky = 1'b1;
      end
    end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      check("missing_ready", 0, 1);
    end
  end

  task automatic step(input logic val, input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b, input logic req, input logic wr,
      input logic [2:0] addr, input logic [7:0] wd);
    logic [7:0] rexp;
    bus.Data_val = val;
    bus.Value_a = a;
    bus.Value_b = b;
    bus.Des_req_valid = req;
    bus.Des_wr_rd = wr;
    bus.Des_address = addr;
    bus.Des_value = wd;
    if (val && m_en) begin
      exp_q.push_back(predict(a, b, m_sub, m_sat, cyc + 1 + NSEG));
    end
    rexp = m_read(addr);
    if (req && wr) begin
      if (addr == 3'd0) begin
        m_en = wd[0];
        m_sub = wd[1];
        m_sat = wd[2];
        if (wd[3]) begin
          m_clr_now = 1'b1;
          m_opcnt = '0;
          m_ovfcnt = '0;
          m_shadow = '0;
        end
      end else if (addr == 3'd1 && wd[0]) begin
        m_sticky = 1'b0;
      end
    end
    if (req && !wr && addr == 3'd2) m_shadow = m_opcnt[15:8];
    @(posedge clk);
    #1;
    m_clr_now = 1'b0;
    bus.Data_val = 1'b0;
    bus.Des_req_valid = 1'b0;
    if (req && !wr) begin
      check($sformatf("read_addr%0d", addr), bus.Des_rd_value, rexp);
    end
  endtask

  task automatic op(input logic [WIDTH-1:0] a,
                    input logic [WIDTH-1:0] b);
    step(1'b1, a, b, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] d);
    step(1'b0, '0, '0, 1'b1, 1'b1, addr, d);
  endtask

  task automatic rd(input logic [2:0] addr);
    step(1'b0, '0, '0, 1'b1, 1'b0, addr, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 8'h00);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      idle(1);
      n++;
    end
    check("drain", exp_q.size(), 0);
    idle(1);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", bus.Data_ready, 0);
    check("rst_sum", bus.Sum_result, 0);
    check("rst_carry", bus.Sum_carry, 0);
    check("rst_rdval", bus.Des_rd_value, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    logic [7:0] wd;
    logic [2:0] ra;
    int r;
    bus.Data_val = 1'b0;
    bus.Value_a = '0;
    bus.Value_b = '0;
    bus.Des_req_valid = 1'b0;
    bus.Des_wr_rd = 1'b0;
    bus.Des_address = '0;
    bus.Des_value = '0;
    model_reset();
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);

    rd(3'd0);
    op(16'h00A1, 16'h00C2);
    drain();

    op(16'hFFFF, 16'h0001);
    drain();
    rd(3'd1);
    rd(3'd4);
    wr(3'd0, 8'h05);
    op(16'hFFFF, 16'h0001);
    drain();

    wr(3'd0, 8'h03);
    op(16'h0005, 16'h0038);
    wr(3'd0, 8'h07);
    op(16'h0005, 16'h0038);
    drain();

    wr(3'd0, 8'h09);
    rd(3'd0);
    rd(3'd2);
    op(16'h1234, 16'h4321);
    op(16'hFF00, 16'h0100);
    op(16'h8000, 16'h8000);
    idle(1);
    step(1'b1, 16'h0010, 16'h0001, 1'b1, 1'b1, 3'd0, 8'h03);
    op(16'h0001, 16'h0002);
    op(16'hABCD, 16'hABCD);
    drain();
    rd(3'd2);

    op(16'h1111, 16'h2222);
    op(16'h3333, 16'h4444);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(NSEG + 3);
    rd(3'd0);

    wr(3'd0, 8'h09);
    rd(3'd0);
    rd(3'd2);
    rd(3'd4);
    rd(3'd5);
    wr(3'd6, 8'hAA);
    rd(3'd6);
    rd(3'd7);

    wr(3'd1, 8'h01);
    op(16'hFFFF, 16'h0001);
    idle(NSEG);
    wr(3'd1, 8'h01);
    rd(3'd1);

    op(16'h0001, 16'h0001);
    idle(NSEG);
    wr(3'd0, 8'h09);
    drain();
    rd(3'd2);

    for (int i = 0; i < 260; i++) op(16'hFFFF, 16'h0001);
    drain();
    rd(3'd4);
    rd(3'd2);
    rd(3'd3);
    op(16'h0002, 16'h0003);
    op(16'h0004, 16'h0005);
    drain();
    rd(3'd3);
    rd(3'd2);

    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : WIDTH'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'h0000 : WIDTH'($urandom);
      r = $urandom_range(0, 15);
      ra = 3'($urandom_range(0, 7));
      wd = {4'b0, ($urandom_range(0, 15) == 0),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 5) != 0)};
      if (r == 0) begin
        step(1'($urandom), a, b, 1'b1, 1'b1, 3'd0, wd);
      end else if (r == 1) begin
        step(1'($urandom), a, b, 1'b1, 1'b1, 3'd1, 8'h01);
      end else if (r < 5) begin
        step(1'($urandom), a, b, 1'b1, 1'b0, ra, 8'h00);
      end else begin
        step(1'($urandom_range(0, 3) != 0), a, b,
             1'b0, 1'b0, 3'd0, 8'h00);
      end
    end
    drain();
    rd(3'd1);
    rd(3'd2);
    rd(3'd3);
    rd(3'd4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
